// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: one barrel level per stage, valid/ready at both ends.
// Stage k applies a shift of 2^k when shamt bit k is set. The op, tag, shamt,
// sign and running carry travel with the data.
module pipelined_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_carry,
  output logic               out_zero,
  output logic [TAG_W-1:0]   out_tag
);

  typedef enum logic [1:0] {
    OpSll = 2'b00,
    OpSrl = 2'b01,
    OpSra = 2'b10,
    OpRol = 2'b11
  } op_e;

  // Stage registers
  logic               valid_q [SHAMT_W];
  logic [WIDTH-1:0]   data_q  [SHAMT_W];
  logic [SHAMT_W-1:0] shamt_q [SHAMT_W];
  op_e                op_q    [SHAMT_W];
  logic [TAG_W-1:0]   tag_q   [SHAMT_W];
  logic               carry_q [SHAMT_W];
  logic               sign_q  [SHAMT_W];

  // Values presented to each stage by its predecessor (stage 0 sees the ports)
  logic               src_valid [SHAMT_W];
  logic [WIDTH-1:0]   src_data  [SHAMT_W];
  logic [SHAMT_W-1:0] src_shamt [SHAMT_W];
  op_e                src_op    [SHAMT_W];
  logic [TAG_W-1:0]   src_tag   [SHAMT_W];
  logic               src_carry [SHAMT_W];
  logic               src_sign  [SHAMT_W];

  logic [WIDTH-1:0]   data_d  [SHAMT_W];
  logic               carry_d [SHAMT_W];

  // take[k]: stage k loads this cycle (it is empty or everything ahead of it moves)
  logic               take [SHAMT_W];

  // Backpressure chain, computed from the output end; no dependence on in_valid
  always_comb begin : take_chain
    logic acc;
    acc = out_ready;
    for (int k = SHAMT_W - 1; k >= 0; k--) begin
      acc     = acc | ~valid_q[k];
      take[k] = acc;
    end
  end

  // Route each stage's source from the ports or the previous stage
  always_comb begin
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    src_shamt[0] = in_shamt;
    src_op[0]    = op_e'(in_op);
    src_tag[0]   = in_tag;
    src_carry[0] = 1'b0;
    src_sign[0]  = in_data[WIDTH-1];
    for (int k = 1; k < SHAMT_W; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_shamt[k] = shamt_q[k-1];
      src_op[k]    = op_q[k-1];
      src_tag[k]   = tag_q[k-1];
      src_carry[k] = carry_q[k-1];
      src_sign[k]  = sign_q[k-1];
    end
  end

  // One barrel level per stage; carry only changes on levels that shift
  always_comb begin
    for (int k = 0; k < SHAMT_W; k++) begin
      int unsigned      amt;
      logic [WIDTH-1:0] hi_out;
      logic [WIDTH-1:0] lo_out;
      amt        = 32'd1 << k;
      hi_out     = src_data[k] >> (WIDTH - amt);
      lo_out     = src_data[k] >> (amt - 1);
      data_d[k]  = src_data[k];
      carry_d[k] = src_carry[k];
      if (|(src_shamt[k] & (SHAMT_W'(1) << k))) begin
        unique case (src_op[k])
          OpSll: begin
            data_d[k]  = src_data[k] << amt;
            carry_d[k] = hi_out[0];
          end
          OpSrl: begin
            data_d[k]  = src_data[k] >> amt;
            carry_d[k] = lo_out[0];
          end
          OpSra: begin
            // Fill uses the operand's original MSB captured at stage 0
            data_d[k]  = (src_data[k] >> amt) |
                         (src_sign[k] ? ~({WIDTH{1'b1}} >> amt) : '0);
            carry_d[k] = lo_out[0];
          end
          OpRol: begin
            data_d[k]  = (src_data[k] << amt) | hi_out;
            carry_d[k] = 1'b0;
          end
        endcase
      end
    end
  end

  // Stage registers; payload only updates on a valid load so empty slots hold data
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        op_q[k]    <= OpSll;
        tag_q[k]   <= '0;
        carry_q[k] <= 1'b0;
        sign_q[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < SHAMT_W; k++) begin
        if (take[k]) begin
          valid_q[k] <= src_valid[k];
          if (src_valid[k]) begin
            data_q[k]  <= data_d[k];
            shamt_q[k] <= src_shamt[k];
            op_q[k]    <= src_op[k];
            tag_q[k]   <= src_tag[k];
            carry_q[k] <= carry_d[k];
            sign_q[k]  <= src_sign[k];
          end
        end
      end
    end
  end

  // Outputs come straight from the last stage
  always_comb begin
    in_ready  = take[0];
    out_valid = valid_q[SHAMT_W-1];
    out_data  = data_q[SHAMT_W-1];
    out_carry = carry_q[SHAMT_W-1];
    out_tag   = tag_q[SHAMT_W-1];
    out_zero  = (data_q[SHAMT_W-1] == '0);
  end

endmodule
